// File: rtl/vesa_timing_gen_prog_if.sv
// Configuration bus for the programmable VESA timing generator.
// Carries staged timing, the write strobe and the shadow status flags.
interface vesa_timing_gen_prog_if #(
    parameter int CNT_W = 13
);
    logic [CNT_W-1:0] cfg_h_active;
    logic [CNT_W-1:0] cfg_h_fp;
    logic [CNT_W-1:0] cfg_h_sync;
    logic [CNT_W-1:0] cfg_h_bp;
    logic [CNT_W-1:0] cfg_v_active;
    logic [CNT_W-1:0] cfg_v_fp;
    logic [CNT_W-1:0] cfg_v_sync;
    logic [CNT_W-1:0] cfg_v_bp;
    logic             cfg_hs_pol;
    logic             cfg_vs_pol;
    logic             cfg_wr;
    logic             cfg_pending;
    logic             cfg_applied;
    logic             cfg_err;

    modport master (
        output cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
        output cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
        output cfg_hs_pol, cfg_vs_pol, cfg_wr,
        input  cfg_pending, cfg_applied, cfg_err
    );

    modport slave (
        input  cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
        input  cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
        input  cfg_hs_pol, cfg_vs_pol, cfg_wr,
        output cfg_pending, cfg_applied, cfg_err
    );
endinterface

// File: rtl/vesa_timing_gen_prog.sv
// Runtime-programmable VESA raster timing generator.
// Shadowed timing is applied only on frame boundaries or at start.
module vesa_timing_gen_prog #(
    parameter int CNT_W        = 13,
    parameter int H_ACTIVE_DEF = 3840,
    parameter int H_FP_DEF     = 48,
    parameter int H_SYNC_DEF   = 32,
    parameter int H_BP_DEF     = 80,
    parameter int V_ACTIVE_DEF = 2160,
    parameter int V_FP_DEF     = 3,
    parameter int V_SYNC_DEF   = 8,
    parameter int V_BP_DEF     = 50,
    parameter int HS_POL_DEF   = 0,
    parameter int VS_POL_DEF   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    vesa_timing_gen_prog_if.slave cfg,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic                 frame_valid,
    output logic                 sof,
    output logic                 eol,
    output logic [CNT_W-1:0]     h_count,
    output logic [CNT_W-1:0]     v_count,
    output logic                 running
);
    localparam int TW = CNT_W + 2;
    localparam logic [TW-1:0] MAX_TOTAL = TW'(1) << CNT_W;

    typedef struct packed {
        logic [CNT_W-1:0] h_active;
        logic [CNT_W-1:0] h_fp;
        logic [CNT_W-1:0] h_sync;
        logic [CNT_W-1:0] h_bp;
        logic [CNT_W-1:0] v_active;
        logic [CNT_W-1:0] v_fp;
        logic [CNT_W-1:0] v_sync;
        logic [CNT_W-1:0] v_bp;
        logic             hs_pol;
        logic             vs_pol;
    } timing_t;

    localparam timing_t TIMING_DEF = '{
        h_active: CNT_W'(H_ACTIVE_DEF),
        h_fp:     CNT_W'(H_FP_DEF),
        h_sync:   CNT_W'(H_SYNC_DEF),
        h_bp:     CNT_W'(H_BP_DEF),
        v_active: CNT_W'(V_ACTIVE_DEF),
        v_fp:     CNT_W'(V_FP_DEF),
        v_sync:   CNT_W'(V_SYNC_DEF),
        v_bp:     CNT_W'(V_BP_DEF),
        hs_pol:   1'(HS_POL_DEF),
        vs_pol:   1'(VS_POL_DEF)
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    function automatic logic [TW-1:0] sum4(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b,
        input logic [CNT_W-1:0] c,
        input logic [CNT_W-1:0] d
    );
        return TW'(a) + TW'(b) + TW'(c) + TW'(d);
    endfunction

    state_t           state_q, state_d;
    timing_t          live_q, shadow_q, cfg_in;
    logic             pending_q, applied_q, err_q;
    logic [CNT_W-1:0] h_q, v_q;
    logic             start_evt, wrap_evt, load_evt;

    logic [TW-1:0] h_total, v_total;
    logic [TW-1:0] in_h_total, in_v_total;
    logic [TW-1:0] h_ss, h_se, v_ss, v_se;
    logic [TW-1:0] h_ext, v_ext;
    logic          h_last, v_last, frame_end;
    logic          h_win, v_win, v_act, cfg_ok;

    assign cfg_in = '{
        h_active: cfg.cfg_h_active,
        h_fp:     cfg.cfg_h_fp,
        h_sync:   cfg.cfg_h_sync,
        h_bp:     cfg.cfg_h_bp,
        v_active: cfg.cfg_v_active,
        v_fp:     cfg.cfg_v_fp,
        v_sync:   cfg.cfg_v_sync,
        v_bp:     cfg.cfg_v_bp,
        hs_pol:   cfg.cfg_hs_pol,
        vs_pol:   cfg.cfg_vs_pol
    };

    assign h_total = sum4(live_q.h_active, live_q.h_fp,
                          live_q.h_sync, live_q.h_bp);
    assign v_total = sum4(live_q.v_active, live_q.v_fp,
                          live_q.v_sync, live_q.v_bp);
    assign in_h_total = sum4(cfg_in.h_active, cfg_in.h_fp,
                             cfg_in.h_sync, cfg_in.h_bp);
    assign in_v_total = sum4(cfg_in.v_active, cfg_in.v_fp,
                             cfg_in.v_sync, cfg_in.v_bp);

    // Front porch may be zero; every other field must be non-zero.
    assign cfg_ok = (cfg_in.h_active != '0) && (cfg_in.h_sync != '0) &&
                    (cfg_in.h_bp != '0) && (cfg_in.v_active != '0) &&
                    (cfg_in.v_sync != '0) && (cfg_in.v_bp != '0) &&
                    (in_h_total <= MAX_TOTAL) && (in_v_total <= MAX_TOTAL);

    assign h_ext = TW'(h_q);
    assign v_ext = TW'(v_q);
    assign h_ss  = TW'(live_q.h_active) + TW'(live_q.h_fp);
    assign h_se  = h_ss + TW'(live_q.h_sync);
    assign v_ss  = TW'(live_q.v_active) + TW'(live_q.v_fp);
    assign v_se  = v_ss + TW'(live_q.v_sync);

    assign h_last    = (h_ext == h_total - TW'(1));
    assign v_last    = (v_ext == v_total - TW'(1));
    assign frame_end = h_last && v_last;
    assign h_win     = (h_ext >= h_ss) && (h_ext < h_se);
    assign v_win     = (v_ext >= v_ss) && (v_ext < v_se);
    assign v_act     = (v_ext < TW'(live_q.v_active));

    assign h_count = h_q;
    assign v_count = v_q;
    assign cfg.cfg_pending = pending_q;
    assign cfg.cfg_applied = applied_q;
    assign cfg.cfg_err     = err_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: DRAIN finishes the frame unless re-enabled.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (enable) state_d = S_RUN;
            S_RUN:   if (!enable) state_d = S_DRAIN;
            S_DRAIN: begin
                if (enable)         state_d = S_RUN;
                else if (frame_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: raster activity and shadow-load moments.
    always_comb begin
        running   = (state_q != S_IDLE);
        start_evt = (state_q == S_IDLE) && enable;
        wrap_evt  = running && frame_end;
        load_evt  = start_evt || wrap_evt;
    end

    // Shadow capture and live update; a same-cycle write lands after the copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q    <= TIMING_DEF;
            shadow_q  <= TIMING_DEF;
            pending_q <= 1'b0;
            applied_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            applied_q <= 1'b0;
            err_q     <= 1'b0;
            if (load_evt && pending_q) begin
                live_q    <= shadow_q;
                applied_q <= 1'b1;
                pending_q <= 1'b0;
            end
            if (cfg.cfg_wr) begin
                if (cfg_ok) begin
                    shadow_q  <= cfg_in;
                    pending_q <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Raster counters, held at the origin while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (!running) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_last) begin
            h_q <= '0;
            v_q <= v_last ? '0 : v_q + 1'b1;
        end else begin
            h_q <= h_q + 1'b1;
        end
    end

    // Registered timing outputs decoded from the current counter value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~TIMING_DEF.hs_pol;
            vsync       <= ~TIMING_DEF.vs_pol;
            de          <= 1'b0;
            frame_valid <= 1'b0;
            sof         <= 1'b0;
            eol         <= 1'b0;
        end else if (!running) begin
            hsync       <= ~live_q.hs_pol;
            vsync       <= ~live_q.vs_pol;
            de          <= 1'b0;
            frame_valid <= 1'b0;
            sof         <= 1'b0;
            eol         <= 1'b0;
        end else begin
            hsync       <= live_q.hs_pol ? h_win : ~h_win;
            vsync       <= live_q.vs_pol ? v_win : ~v_win;
            de          <= v_act && (h_ext < TW'(live_q.h_active));
            frame_valid <= v_act;
            sof         <= (h_q == '0) && (v_q == '0);
            eol         <= h_last;
        end
    end
endmodule

// File: tb/tb_vesa_timing_gen_prog.sv
// Scoreboard bench for vesa_timing_gen_prog.
// Expected raster samples are queued when stimulus is driven.
module tb_vesa_timing_gen_prog;
    localparam int CW = 13;

    typedef struct packed {
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic run, de, hs, vs, fv, sof, eol;
    } exp_t;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hp, vp;
    } mode_t;

    logic clk = 1'b0;
    logic rst_n, enable;
    logic hsync, vsync, de, frame_valid, sof, eol, running;
    logic [CW-1:0] h_count, v_count;

    vesa_timing_gen_prog_if #(.CNT_W(CW)) cfg ();

    vesa_timing_gen_prog #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg(cfg),
        .hsync(hsync), .vsync(vsync), .de(de),
        .frame_valid(frame_valid), .sof(sof), .eol(eol),
        .h_count(h_count), .v_count(v_count), .running(running)
    );

    always #5 clk = ~clk;

    exp_t got;
    assign got = {h_count, v_count, running, de, hsync, vsync,
                  frame_valid, sof, eol};

    int checks = 0;
    int failures = 0;
    exp_t q[$];

    mode_t MA  = '{8, 2, 2, 4, 4, 1, 1, 2, 1'b0, 1'b0};
    mode_t MB  = '{6, 2, 2, 4, 4, 1, 1, 2, 1'b0, 1'b0};
    mode_t MP  = '{8, 2, 2, 4, 4, 1, 1, 2, 1'b1, 1'b1};
    mode_t MD  = '{3840, 48, 32, 80, 2160, 3, 8, 50, 1'b0, 1'b0};

    function automatic int htot(mode_t m);
        return m.ha + m.hf + m.hs + m.hb;
    endfunction

    function automatic int vtot(mode_t m);
        return m.va + m.vf + m.vs + m.vb;
    endfunction

    function automatic exp_t dec(mode_t m, int h, int v);
        exp_t e;
        bit hw, vw;
        e = '0;
        hw = (h >= m.ha + m.hf) && (h < m.ha + m.hf + m.hs);
        vw = (v >= m.va + m.vf) && (v < m.va + m.vf + m.vs);
        e.de  = (h < m.ha) && (v < m.va);
        e.fv  = (v < m.va);
        e.hs  = m.hp ? hw : !hw;
        e.vs  = m.vp ? vw : !vw;
        e.sof = (h == 0) && (v == 0);
        e.eol = (h == htot(m) - 1);
        return e;
    endfunction

    function automatic exp_t idle_out(bit hp, bit vp);
        exp_t e;
        e = '0;
        e.hs = !hp;
        e.vs = !vp;
        return e;
    endfunction

    // Sample k of a running frame: counters at k, outputs from k-1.
    function automatic exp_t mk(mode_t m, int k, mode_t pm, bit prun);
        exp_t e;
        int ht;
        ht = htot(m);
        if (k == 0)
            e = prun ? dec(pm, htot(pm) - 1, vtot(pm) - 1)
                     : idle_out(pm.hp, pm.vp);
        else
            e = dec(m, (k - 1) % ht, (k - 1) / ht);
        e.h = CW'(k % ht);
        e.v = CW'(k / ht);
        e.run = 1'b1;
        return e;
    endfunction

    task automatic push_frame(mode_t m, mode_t pm, bit prun, int n);
        for (int k = 0; k < n; k++) q.push_back(mk(m, k, pm, prun));
    endtask

    task automatic drive_cfg(mode_t m);
        cfg.cfg_h_active = CW'(m.ha);
        cfg.cfg_h_fp     = CW'(m.hf);
        cfg.cfg_h_sync   = CW'(m.hs);
        cfg.cfg_h_bp     = CW'(m.hb);
        cfg.cfg_v_active = CW'(m.va);
        cfg.cfg_v_fp     = CW'(m.vf);
        cfg.cfg_v_sync   = CW'(m.vs);
        cfg.cfg_v_bp     = CW'(m.vb);
        cfg.cfg_hs_pol   = m.hp;
        cfg.cfg_vs_pol   = m.vp;
        cfg.cfg_wr       = 1'b1;
    endtask

    task automatic write_cfg(mode_t m);
        drive_cfg(m);
        @(negedge clk);
        cfg.cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        enable = 1'b0;
        drive_cfg(MA);
        cfg.cfg_wr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e = idle_out(1'b0, 1'b0);
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_outputs: got %h want %h", got, e);
        end
        checks++;
        if (cfg.cfg_pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_pending: got %b want 0", cfg.cfg_pending);
        end
        checks++;
        if (cfg.cfg_applied !== 1'b0) begin
            failures++;
            $display("FAIL reset_applied: got %b want 0", cfg.cfg_applied);
        end
        checks++;
        if (cfg.cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err: got %b want 0", cfg.cfg_err);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int nsof;
        write_cfg(MA);
        checks++;
        if (cfg.cfg_pending !== 1'b1 || cfg.cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL basic_wr: got pend=%b err=%b want 1 0",
                     cfg.cfg_pending, cfg.cfg_err);
        end
        enable = 1'b1;
        push_frame(MA, MD, 1'b0, 128);
        push_frame(MA, MA, 1'b1, 128);
        @(negedge clk);
        nsof = 0;
        for (int i = 0; i < 256; i++) begin
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL basic[%0d]: got %h want %h", i, got, e);
            end
            if (sof) nsof++;
            if (i == 0) begin
                checks++;
                if (cfg.cfg_applied !== 1'b1 || cfg.cfg_pending !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_apply: got app=%b pend=%b want 1 0",
                             cfg.cfg_applied, cfg.cfg_pending);
                end
            end
            if (i == 1) begin
                checks++;
                if (cfg.cfg_applied !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_apply_pulse: got %b want 0",
                             cfg.cfg_applied);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (nsof != 2) begin
            failures++;
            $display("FAIL basic_sof_count: got %0d want 2", nsof);
        end
    endtask

    task automatic test_reconfig();
        exp_t e;
        push_frame(MA, MA, 1'b1, 128);
        for (int i = 0; i < 352; i++) begin
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reconfig[%0d]: got %h want %h", i, got, e);
            end
            if (i == 33 || i == 127) begin
                checks++;
                if (cfg.cfg_pending !== 1'b1) begin
                    failures++;
                    $display("FAIL reconfig_pend[%0d]: got %b want 1",
                             i, cfg.cfg_pending);
                end
            end
            if (i == 128) begin
                checks++;
                if (cfg.cfg_applied !== 1'b1 || cfg.cfg_pending !== 1'b0) begin
                    failures++;
                    $display("FAIL reconfig_apply: got app=%b pend=%b want 1 0",
                             cfg.cfg_applied, cfg.cfg_pending);
                end
            end
            if (i == 32) begin
                drive_cfg(MB);
                push_frame(MB, MA, 1'b1, 112);
                push_frame(MB, MB, 1'b1, 112);
            end
            @(negedge clk);
            cfg.cfg_wr = 1'b0;
        end
    endtask

    task automatic test_invalid();
        exp_t e;
        mode_t bad_sync, big, edge_m, bad_va;
        bad_sync = MB;
        bad_sync.hs = 0;
        big = '{8000, 100, 50, 50, 4, 1, 1, 2, 1'b0, 1'b0};
        edge_m = '{8000, 0, 92, 100, 4, 1, 1, 2, 1'b0, 1'b0};
        bad_va = MB;
        bad_va.va = 0;
        push_frame(MB, MB, 1'b1, 112);
        push_frame(MB, MB, 1'b1, 112);
        for (int i = 0; i < 224; i++) begin
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL invalid[%0d]: got %h want %h", i, got, e);
            end
            if (i == 6 || i == 11) begin
                checks++;
                if (cfg.cfg_err !== 1'b1 || cfg.cfg_pending !== 1'b0) begin
                    failures++;
                    $display("FAIL invalid_rej[%0d]: got err=%b pend=%b want 1 0",
                             i, cfg.cfg_err, cfg.cfg_pending);
                end
            end
            if (i == 16 || i == 21) begin
                checks++;
                if (cfg.cfg_err !== 1'b0 || cfg.cfg_pending !== 1'b1) begin
                    failures++;
                    $display("FAIL invalid_acc[%0d]: got err=%b pend=%b want 0 1",
                             i, cfg.cfg_err, cfg.cfg_pending);
                end
            end
            if (i == 26) begin
                checks++;
                if (cfg.cfg_err !== 1'b1 || cfg.cfg_pending !== 1'b1) begin
                    failures++;
                    $display("FAIL invalid_keep: got err=%b pend=%b want 1 1",
                             cfg.cfg_err, cfg.cfg_pending);
                end
            end
            if (i == 27) begin
                checks++;
                if (cfg.cfg_err !== 1'b0) begin
                    failures++;
                    $display("FAIL invalid_err_pulse: got %b want 0", cfg.cfg_err);
                end
            end
            if (i == 112) begin
                checks++;
                if (cfg.cfg_applied !== 1'b1 || cfg.cfg_pending !== 1'b0) begin
                    failures++;
                    $display("FAIL invalid_apply: got app=%b pend=%b want 1 0",
                             cfg.cfg_applied, cfg.cfg_pending);
                end
            end
            if (i == 5)  drive_cfg(bad_sync);
            if (i == 10) drive_cfg(big);
            if (i == 15) drive_cfg(edge_m);
            if (i == 20) drive_cfg(MB);
            if (i == 25) drive_cfg(bad_va);
            @(negedge clk);
            cfg.cfg_wr = 1'b0;
        end
    endtask

    task automatic test_drain();
        exp_t e;
        push_frame(MB, MB, 1'b1, 112);
        push_frame(MB, MB, 1'b1, 112);
        e = dec(MB, htot(MB) - 1, vtot(MB) - 1);
        q.push_back(e);
        q.push_back(idle_out(1'b0, 1'b0));
        q.push_back(idle_out(1'b0, 1'b0));
        for (int i = 0; i < 227; i++) begin
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL drain[%0d]: got %h want %h", i, got, e);
            end
            if (i == 14 || i == 126) enable = 1'b0;
            if (i == 42) enable = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_polarity();
        exp_t e;
        write_cfg(MP);
        checks++;
        if (cfg.cfg_pending !== 1'b1 || hsync !== 1'b1 || vsync !== 1'b1) begin
            failures++;
            $display("FAIL pol_idle: got pend=%b hs=%b vs=%b want 1 1 1",
                     cfg.cfg_pending, hsync, vsync);
        end
        enable = 1'b1;
        push_frame(MP, MB, 1'b0, 128);
        push_frame(MP, MP, 1'b1, 128);
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL pol[%0d]: got %h want %h", i, got, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        repeat (5) @(negedge clk);
        write_cfg(MA);
        checks++;
        if (cfg.cfg_pending !== 1'b1 || h_count == '0) begin
            failures++;
            $display("FAIL rst_pre: got pend=%b h=%0d want 1 nonzero",
                     cfg.cfg_pending, h_count);
        end
        rst_n = 1'b0;
        #1;
        e = idle_out(1'b0, 1'b0);
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL rst_async: got %h want %h", got, e);
        end
        checks++;
        if (cfg.cfg_pending !== 1'b0) begin
            failures++;
            $display("FAIL rst_pend: got %b want 0", cfg.cfg_pending);
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        push_frame(MD, MD, 1'b0, 8100);
        @(negedge clk);
        for (int i = 0; i < 8100; i++) begin
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL default[%0d]: got %h want %h", i, got, e);
            end
            if (i == 0) begin
                checks++;
                if (cfg.cfg_applied !== 1'b0 || cfg.cfg_pending !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_discard: got app=%b pend=%b want 0 0",
                             cfg.cfg_applied, cfg.cfg_pending);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reconfig();
        test_invalid();
        test_drain();
        test_polarity();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
